// File: rtl/fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_pkg: shared state encoding, redirect selects and reset PC    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2,
        TRAP  = 2'd3
    } fetch_state_t;

    localparam logic [1:0] SEL_SEQ  = 2'b00;
    localparam logic [1:0] SEL_BR   = 2'b01;
    localparam logic [1:0] SEL_JAL  = 2'b10;
    localparam logic [1:0] SEL_JALR = 2'b11;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/pc_target_calc.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pc_target_calc: redirect target select/add and misalignment flag   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module pc_target_calc
    import fetch_pkg::*;
(
    input  logic [1:0]  sel,
    input  logic [31:0] pc,
    input  logic [31:0] b_imm,
    input  logic [31:0] j_imm,
    input  logic [31:0] alu,
    output logic [31:0] target,
    output logic        redirect,
    output logic        misaligned
);

    always_comb begin
        target = pc;
        case (sel)
            SEL_BR:   target = pc + b_imm;
            SEL_JAL:  target = pc + j_imm;
            SEL_JALR: target = alu & ~32'h1;
            default:  target = pc;
        endcase
    end

    assign redirect   = (sel != SEL_SEQ);
    assign misaligned = redirect && (target[1:0] != 2'b00);

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_sequencer: one-outstanding instruction fetch with redirects  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic [1:0]  redir_sel,
    input  logic [31:0] redir_pc,
    input  logic [31:0] redir_b_imm,
    input  logic [31:0] redir_j_imm,
    input  logic [31:0] redir_alu,
    output logic        trap,
    output logic [31:0] trap_pc
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  pend_target;

    logic [31:0]  target;
    logic         redirect;
    logic         misaligned;

    pc_target_calc u_target (
        .sel        (redir_sel),
        .pc         (redir_pc),
        .b_imm      (redir_b_imm),
        .j_imm      (redir_j_imm),
        .alu        (redir_alu),
        .target     (target),
        .redirect   (redirect),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= FETCH;
            pc          <= RESET_VECTOR;
            pend_target <= '0;
            imem_req    <= 1'b1;
            imem_addr   <= RESET_VECTOR;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            trap        <= 1'b0;
            trap_pc     <= '0;
        end else if (state != TRAP) begin
            if (redirect) begin
                if (misaligned) begin
                    state       <= TRAP;
                    trap        <= 1'b1;
                    trap_pc     <= target;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end else if ((state == FETCH || state == DRAIN) && !imem_ack) begin
                    // Request still in flight: keep address stable, remember where to go
                    state       <= DRAIN;
                    pend_target <= target;
                end else begin
                    state       <= FETCH;
                    pc          <= target;
                    imem_req    <= 1'b1;
                    imem_addr   <= target;
                    instr_valid <= 1'b0;
                end
            end else begin
                case (state)
                    FETCH: begin
                        if (imem_ack) begin
                            instr       <= imem_rdata;
                            instr_pc    <= imem_addr;
                            pc          <= imem_addr + 32'd4;
                            instr_valid <= 1'b1;
                            imem_req    <= 1'b0;
                            state       <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (instr_ready) begin
                            instr_valid <= 1'b0;
                            imem_req    <= 1'b1;
                            imem_addr   <= pc;
                            state       <= FETCH;
                        end
                    end
                    DRAIN: begin
                        if (imem_ack) begin
                            pc        <= pend_target;
                            imem_addr <= pend_target;
                            state     <= FETCH;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fetch_sequencer: directed + random checks against a flag model  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic [1:0]  redir_sel = 2'b00;
    logic [31:0] redir_pc = '0;
    logic [31:0] redir_b_imm = '0;
    logic [31:0] redir_j_imm = '0;
    logic [31:0] redir_alu = '0;
    logic        trap;
    logic [31:0] trap_pc;

    fetch_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redir_sel   (redir_sel),
        .redir_pc    (redir_pc),
        .redir_b_imm (redir_b_imm),
        .redir_j_imm (redir_j_imm),
        .redir_alu   (redir_alu),
        .trap        (trap),
        .trap_pc     (trap_pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: what is outstanding, what is held, and where fetching resumes
    logic        m_req, m_valid, m_trap, m_stale;
    logic [31:0] m_addr, m_next, m_instr, m_ipc, m_trap_pc, m_resume;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    task automatic compare_all();
        check("imem_req",    {31'd0, imem_req},    {31'd0, m_req});
        if (m_req) check("imem_addr", imem_addr, m_addr);
        check("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
        if (m_valid) begin
            check("instr",    instr,    m_instr);
            check("instr_pc", instr_pc, m_ipc);
        end
        check("trap",        {31'd0, trap},        {31'd0, m_trap});
        check("trap_pc",     trap_pc,              m_trap_pc);
    endtask

    task automatic model_reset();
        m_req = 1'b1; m_addr = 32'h0; m_next = 32'h0; m_valid = 1'b0;
        m_instr = '0; m_ipc = '0; m_trap = 1'b0; m_trap_pc = '0;
        m_stale = 1'b0; m_resume = '0;
    endtask

    task automatic model_update();
        logic [31:0] t;
        logic acked;
        acked = m_req && imem_ack;
        case (redir_sel)
            2'b01:   t = redir_pc + redir_b_imm;
            2'b10:   t = redir_pc + redir_j_imm;
            default: t = redir_alu - (redir_alu % 2);
        endcase
        if (m_trap) begin
        end else if (redir_sel != 2'b00) begin
            if (t % 4 != 0) begin
                m_trap = 1'b1; m_trap_pc = t; m_req = 1'b0; m_valid = 1'b0;
            end else if (m_req && !acked) begin
                m_stale = 1'b1; m_resume = t;
            end else begin
                m_stale = 1'b0; m_req = 1'b1; m_addr = t; m_next = t; m_valid = 1'b0;
            end
        end else if (acked) begin
            if (m_stale) begin
                m_stale = 1'b0; m_addr = m_resume; m_next = m_resume;
            end else begin
                m_instr = imem_rdata; m_ipc = m_addr; m_next = m_addr + 4;
                m_valid = 1'b1; m_req = 1'b0;
            end
        end else if (m_valid && instr_ready) begin
            m_valid = 1'b0; m_req = 1'b1; m_addr = m_next;
        end
    endtask

    task automatic step(input logic a, input logic r, input logic [1:0] s,
                        input logic [31:0] rp, input logic [31:0] bi,
                        input logic [31:0] ji, input logic [31:0] al);
        @(negedge clk);
        compare_all();
        imem_ack = a; instr_ready = r; redir_sel = s;
        redir_pc = rp; redir_b_imm = bi; redir_j_imm = ji; redir_alu = al;
        imem_rdata = $urandom;
        @(posedge clk);
        model_update();
    endtask

    task automatic idle(input logic a, input logic r);
        step(a, r, 2'b00, '0, '0, '0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        imem_ack = 1'b0; instr_ready = 1'b0; redir_sel = 2'b00;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [31:0] bi, ji, al;
        logic [1:0]  s;
        logic        bad;
        model_reset();
        do_reset();

        repeat (8) idle(1'b1, 1'b1);

        idle(1'b1, 1'b0);
        repeat (3) idle(1'b0, 1'b0);
        idle(1'b0, 1'b1);

        step(1'b0, 1'b1, 2'b01, 32'h10, 32'hFFFF_FFF8, '0, '0);
        idle(1'b0, 1'b1);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);

        step(1'b0, 1'b1, 2'b11, '0, '0, '0, 32'h101);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);

        step(1'b0, 1'b0, 2'b10, 32'h100, '0, 32'h2, '0);
        repeat (4) idle(1'b1, 1'b1);

        do_reset();
        step(1'b0, 1'b0, 2'b01, 32'h40, 32'h20, '0, '0);
        idle(1'b0, 1'b0);
        do_reset();
        repeat (4) idle(1'b1, 1'b1);

        idle(1'b0, 1'b0);
        step(1'b1, 1'b1, 2'b10, 32'hFFFF_FFF8, '0, 32'h4, '0);
        repeat (6) idle(1'b1, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            if ((i % 250) == 249 || (m_trap && $urandom_range(0, 7) == 0)) do_reset();
            s   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            bad = ($urandom_range(0, 29) == 0);
            bi  = $urandom & 32'hFFFF_FFFC;
            ji  = $urandom & 32'hFFFF_FFFC;
            al  = $urandom & 32'hFFFF_FFFD;
            if (bad) begin
                bi = bi | 32'h2; ji = ji | 32'h2; al = al | 32'h2;
            end
            step($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, s,
                 $urandom & 32'hFFFF_FFFC, bi, ji, al);
        end

        @(negedge clk);
        compare_all();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
